// File: rtl/bram_access_seq_if.sv
// Core-request / BRAM-port bundle for the instruction/data BRAM sequencer.
// master = the sequencer; slave = the core and BRAM environment around it.
interface bram_access_seq_if #(
  parameter int WORD_SIZE = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [15:0]          req_pc;
  logic [2:0]           req_draddr;
  logic [2:0]           req_dwaddr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 req_we;

  logic                 i1re;
  logic                 i2re;
  logic                 dre;
  logic                 gwe;
  logic [15:0]          i1addr;
  logic [15:0]          i2addr;
  logic [2:0]           draddr;
  logic [2:0]           dwaddr;
  logic [WORD_SIZE-1:0] din;
  logic                 dwe;
  logic [15:0]          i1out;
  logic [15:0]          i2out;
  logic [WORD_SIZE-1:0] dout;

  logic                 resp_valid;
  logic [15:0]          resp_insn1;
  logic [15:0]          resp_insn2;
  logic [WORD_SIZE-1:0] resp_data;
  logic [15:0]          frame_cnt;

  modport master (
    input  req_valid, req_pc, req_draddr, req_dwaddr, req_wdata, req_we,
    input  i1out, i2out, dout,
    output req_ready, i1re, i2re, dre, gwe, i1addr, i2addr, draddr, dwaddr,
    output din, dwe, resp_valid, resp_insn1, resp_insn2, resp_data, frame_cnt
  );

  modport slave (
    output req_valid, req_pc, req_draddr, req_dwaddr, req_wdata, req_we,
    output i1out, i2out, dout,
    input  req_ready, i1re, i2re, dre, gwe, i1addr, i2addr, draddr, dwaddr,
    input  din, dwe, resp_valid, resp_insn1, resp_insn2, resp_data, frame_cnt
  );
endinterface

// File: rtl/bram_access_seq.sv
// Initiator for the time-multiplexed BRAM port: one core request becomes an
// i1re/i2re/dre/gwe strobe frame, and the returned words come back as one response.
module bram_access_seq #(
  parameter int WORD_SIZE = 16
) (
  input logic              idclk,
  input logic              rst,
  bram_access_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    P4   = 3'd4
  } state_e;

  state_e               state_q;
  logic                 req_ready_q;
  logic                 i1re_q;
  logic                 i2re_q;
  logic                 dre_q;
  logic                 gwe_q;
  logic [15:0]          i1addr_q;
  logic [15:0]          i2addr_q;
  logic [2:0]           draddr_q;
  logic [2:0]           dwaddr_q;
  logic [WORD_SIZE-1:0] din_q;
  logic                 dwe_q;
  logic                 resp_valid_q;
  logic [15:0]          resp_insn1_q;
  logic [15:0]          resp_insn2_q;
  logic [WORD_SIZE-1:0] resp_data_q;
  logic [15:0]          frame_cnt_q;
  logic                 accept_d;

  assign accept_d = bus.req_valid && req_ready_q;

  // Frame sequencer: state, one-hot strobes, request latches and response capture.
  always_ff @(posedge idclk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      i1re_q       <= 1'b0;
      i2re_q       <= 1'b0;
      dre_q        <= 1'b0;
      gwe_q        <= 1'b0;
      i1addr_q     <= 16'h0000;
      i2addr_q     <= 16'h0000;
      draddr_q     <= 3'd0;
      dwaddr_q     <= 3'd0;
      din_q        <= '0;
      dwe_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_insn1_q <= 16'h0000;
      resp_insn2_q <= 16'h0000;
      resp_data_q  <= '0;
      frame_cnt_q  <= 16'h0000;
    end else begin
      resp_valid_q <= 1'b0;
      i1re_q       <= 1'b0;
      i2re_q       <= 1'b0;
      dre_q        <= 1'b0;
      gwe_q        <= 1'b0;

      if (accept_d) begin
        i1addr_q <= bus.req_pc;
        i2addr_q <= bus.req_pc + 16'd1;
        draddr_q <= bus.req_draddr;
        dwaddr_q <= bus.req_dwaddr;
        din_q    <= bus.req_wdata;
        dwe_q    <= bus.req_we;
      end

      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q     <= P1;
            i1re_q      <= 1'b1;
            req_ready_q <= 1'b0;
          end else begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end
        end
        P1: begin
          state_q     <= P2;
          i2re_q      <= 1'b1;
          req_ready_q <= 1'b0;
        end
        P2: begin
          resp_insn1_q <= bus.i1out;
          state_q      <= P3;
          dre_q        <= 1'b1;
          req_ready_q  <= 1'b0;
        end
        P3: begin
          resp_insn2_q <= bus.i2out;
          state_q      <= P4;
          gwe_q        <= 1'b1;
          req_ready_q  <= 1'b1;
        end
        P4: begin
          // dout here was read on the P3 edge, before that edge's write landed.
          resp_data_q  <= bus.dout;
          resp_valid_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + 16'd1;
          if (accept_d) begin
            state_q     <= P1;
            i1re_q      <= 1'b1;
            req_ready_q <= 1'b0;
          end else begin
            state_q     <= IDLE;
            dwe_q       <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          dwe_q       <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.i1re       = i1re_q;
  assign bus.i2re       = i2re_q;
  assign bus.dre        = dre_q;
  assign bus.gwe        = gwe_q;
  assign bus.i1addr     = i1addr_q;
  assign bus.i2addr     = i2addr_q;
  assign bus.draddr     = draddr_q;
  assign bus.dwaddr     = dwaddr_q;
  assign bus.din        = din_q;
  assign bus.dwe        = dwe_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_insn1 = resp_insn1_q;
  assign bus.resp_insn2 = resp_insn2_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_bram_access_seq.sv
// Scoreboard bench for bram_access_seq: a read-first BRAM model answers the strobes,
// stimulus queues hand-computed responses, and a monitor checks each resp_valid pulse.
module tb_bram_access_seq;

  typedef struct {
    logic [15:0] i1;
    logic [15:0] i2;
    logic [15:0] d;
    logic [15:0] fc;
    int          cyc;
  } exp_t;

  logic        idclk = 1'b0;
  logic        rst   = 1'b1;
  int          cyc   = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] exp_fc = 16'h0000;
  logic [15:0] mem_d [8];
  int          k1, k2, k3;

  bram_access_seq_if #(.WORD_SIZE(16)) bus ();

  bram_access_seq #(.WORD_SIZE(16)) dut (
    .idclk (idclk),
    .rst   (rst),
    .bus   (bus.master)
  );

  always #5 idclk = ~idclk;

  always @(posedge idclk) cyc <= cyc + 1;

  function automatic logic [15:0] insn(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  // Read-first BRAM: reads and the dre-edge write share the same clock edge.
  always @(posedge idclk) begin
    if (bus.i1re) bus.i1out <= insn(bus.i1addr);
    if (bus.i2re) bus.i2out <= insn(bus.i2addr);
    if (bus.dre)  bus.dout  <= mem_d[bus.draddr];
    if (bus.dre && bus.dwe) mem_d[bus.dwaddr] <= bus.din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every resp_valid pulse must match the oldest queued expectation.
  always @(negedge idclk) begin
    if (!rst && bus.resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp_cycle", cyc, mon_e.cyc);
        chk("resp_insn1", {16'h0000, bus.resp_insn1}, {16'h0000, mon_e.i1});
        chk("resp_insn2", {16'h0000, bus.resp_insn2}, {16'h0000, mon_e.i2});
        chk("resp_data",  {16'h0000, bus.resp_data},  {16'h0000, mon_e.d});
        chk("frame_cnt",  {16'h0000, bus.frame_cnt},  {16'h0000, mon_e.fc});
      end
    end
  end

  // Presents a request and returns #1 after its accept edge (k = P1 cycle number).
  task automatic send(input logic [15:0] pc, input logic [2:0] dr, input logic [2:0] dw,
                      input logic [15:0] wd, input logic we, input logic push,
                      input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] ed,
                      output int k);
    int n;
    exp_t e;
    n = 0;
    bus.req_valid  = 1'b1;
    bus.req_pc     = pc;
    bus.req_draddr = dr;
    bus.req_dwaddr = dw;
    bus.req_wdata  = wd;
    bus.req_we     = we;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge idclk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got req_ready low for %0d cycles expected high", n);
    end
    @(posedge idclk);
    #1;
    k = cyc;
    if (push) begin
      exp_fc = exp_fc + 16'd1;
      e.i1 = e1; e.i2 = e2; e.d = ed; e.fc = exp_fc; e.cyc = k + 4;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(negedge idclk);
      n++;
    end
    chk("drain_pending", sb_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, bus.i1re, bus.i2re, bus.dre, bus.gwe};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) mem_d[i] = 16'(i) * 16'h0101;
    mem_d[2] = 16'h1111;
    bus.req_valid = 1'b0; bus.req_pc = 16'h0000; bus.req_draddr = 3'd0;
    bus.req_dwaddr = 3'd0; bus.req_wdata = 16'h0000; bus.req_we = 1'b0;

    repeat (3) @(posedge idclk);
    @(negedge idclk);
    rst = 1'b0;
    chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
    chk("rst_strobes",    strobes(),               32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_frame_cnt",  {16'd0, bus.frame_cnt},  32'd0);
    chk("rst_addrs",      {bus.i1addr, bus.i2addr}, 32'd0);
    chk("rst_dwe_din",    {15'd0, bus.dwe, bus.din}, 32'd0);
    chk("rst_resp",       {bus.resp_insn1, bus.resp_data}, 32'd0);

    // Frame 1: strobe sequence and ready timing.
    send(16'h0010, 3'd5, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5A10, 16'h5A11, 16'h0505, k1);
    bus.req_valid = 1'b0;
    chk("p1_strobe", strobes(), 32'h8);
    chk("p1_ready",  {31'd0, bus.req_ready}, 32'd0);
    chk("p1_i2addr", {16'd0, bus.i2addr}, 32'h0011);
    @(posedge idclk); #1; chk("p2_strobe", strobes(), 32'h4);
    @(posedge idclk); #1; chk("p3_strobe", strobes(), 32'h2);
    @(posedge idclk); #1; chk("p4_strobe", strobes(), 32'h1);
    chk("p4_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge idclk); #1; chk("idle_strobe", strobes(), 32'h0);
    drain();

    // Write 0xBEEF to 3 while reading 5, then read 3 back.
    @(negedge idclk);
    send(16'h0020, 3'd5, 3'd3, 16'hBEEF, 1'b1, 1'b1, 16'h5A20, 16'h5A21, 16'h0505, k1);
    bus.req_valid = 1'b0;
    chk("wr_dwe_p1", {31'd0, bus.dwe}, 32'd1);
    drain();
    chk("wr_dwe_idle", {31'd0, bus.dwe}, 32'd0);
    chk("wr_hold_idle", {13'd0, bus.dwaddr, bus.din}, {13'd0, 3'd3, 16'hBEEF});
    @(negedge idclk);
    send(16'h0030, 3'd3, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5A30, 16'h5A31, 16'hBEEF, k1);
    bus.req_valid = 1'b0;
    drain();

    // Same-frame collision returns the pre-write value.
    @(negedge idclk);
    send(16'h0040, 3'd2, 3'd2, 16'h2222, 1'b1, 1'b1, 16'h5A40, 16'h5A41, 16'h1111, k1);
    bus.req_valid = 1'b0;
    drain();
    @(negedge idclk);
    send(16'h0050, 3'd2, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5A50, 16'h5A51, 16'h2222, k1);
    bus.req_valid = 1'b0;
    drain();

    // Three back-to-back frames with req_valid held high.
    @(negedge idclk);
    send(16'h0100, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5B00, 16'h5B01, 16'h0000, k1);
    send(16'h0104, 3'd1, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5B04, 16'h5B05, 16'h0101, k2);
    send(16'h0108, 3'd4, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5B08, 16'h5B09, 16'h0404, k3);
    bus.req_valid = 1'b0;
    chk("b2b_gap12", k2 - k1, 32'd4);
    chk("b2b_gap23", k3 - k2, 32'd4);
    drain();

    // PC wrap: second fetch address rolls over to 0.
    @(negedge idclk);
    send(16'hFFFF, 3'd7, 3'd0, 16'h0000, 1'b0, 1'b1, 16'hA5FF, 16'h5A00, 16'h0707, k1);
    bus.req_valid = 1'b0;
    chk("wrap_i2addr", {16'd0, bus.i2addr}, 32'h0000);
    drain();

    // Reset during P2 drops the frame.
    @(negedge idclk);
    send(16'h0200, 3'd1, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, k1);
    bus.req_valid = 1'b0;
    @(posedge idclk); #1;
    chk("mid_p2_strobe", strobes(), 32'h4);
    rst = 1'b1;
    @(posedge idclk); #1;
    rst = 1'b0;
    exp_fc = 16'h0000;
    chk("mid_rst_strobes",   strobes(), 32'd0);
    chk("mid_rst_resp",      {31'd0, bus.resp_valid}, 32'd0);
    chk("mid_rst_frame_cnt", {16'd0, bus.frame_cnt}, 32'd0);
    chk("mid_rst_ready",     {31'd0, bus.req_ready}, 32'd1);
    repeat (6) begin
      @(posedge idclk); #1;
      chk("post_rst_quiet", strobes() | {31'd0, bus.resp_valid}, 32'd0);
    end

    // Fresh frame after reset; earlier write to address 3 persists.
    @(negedge idclk);
    send(16'h0003, 3'd3, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h5A03, 16'h5A04, 16'hBEEF, k1);
    bus.req_valid = 1'b0;
    drain();
    repeat (3) @(negedge idclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
